// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate L1 data cache
// One-word lines, big-endian lanes; stalls the CPU on load misses and on every store.
module data_cache #(
  parameter int WIDTH = 32,
  parameter int SETS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_mode,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = WIDTH - IDX - 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [SETS-1:0]   r_valid;
  logic [TW-1:0]     r_tag  [SETS];
  logic [WIDTH-1:0]  r_data [SETS];
  logic              r_refill;

  logic [IDX-1:0]    w_idx;
  logic [TW-1:0]     w_tag;
  logic              w_access, w_hit, w_fill, w_merge;
  logic [WIDTH-1:0]  w_line, w_load, w_wdata, w_merged;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;

  assign w_idx    = cpu_addr[IDX+1:2];
  assign w_tag    = cpu_addr[WIDTH-1:IDX+2];
  assign w_access = cpu_req && (cpu_mode >= 3'd1) && (cpu_mode <= 3'd5);
  assign w_line   = r_data[w_idx];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill   = (r_state == S_FETCH) && mem_ack;
  assign w_merge  = (r_state == S_WRITE) && mem_ack && w_hit;

  always_comb begin
    w_byte = w_line[7:0];
    case (cpu_addr[1:0])
      2'd0:    w_byte = w_line[31:24];
      2'd1:    w_byte = w_line[23:16];
      2'd2:    w_byte = w_line[15:8];
      default: w_byte = w_line[7:0];
    endcase
    w_half = cpu_addr[1] ? w_line[15:0] : w_line[31:16];
    case (cpu_mode)
      3'b010:  w_load = {{16{w_half[15]}}, w_half};
      3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {16'd0, w_half};
      3'b101:  w_load = {24'd0, w_byte};
      default: w_load = w_line;
    endcase
  end

  // Store lanes: be bit3 is the byte at offset 0, i.e. bits [31:24].
  always_comb begin
    case (cpu_mode)
      3'b010, 3'b100: begin
        w_be    = cpu_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{cpu_wdata[15:0]}};
      end
      3'b011, 3'b101: begin
        w_be    = 4'b1000 >> cpu_addr[1:0];
        w_wdata = {4{cpu_wdata[7:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = cpu_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_line[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access && cpu_we)      w_next = S_WRITE;
        else if (w_access && !w_hit) w_next = S_FETCH;
      end
      S_FETCH: if (mem_ack) w_next = S_IDLE;
      S_WRITE: if (mem_ack) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          stall = w_access && (cpu_we || !w_hit);
          if (w_access && !cpu_we && w_hit) cpu_rdata = w_load;
        end
        S_FETCH: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {cpu_addr[WIDTH-1:2], 2'b00};
          mem_be   = 4'b1111;
        end
        S_WRITE: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {cpu_addr[WIDTH-1:2], 2'b00};
          mem_be    = w_be;
          mem_wdata = w_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_refill <= 1'b0;
    end else begin
      r_refill <= w_fill;
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_rdata;
    end else if (w_merge) begin
      r_data[w_idx] <= w_merged;
    end
  end

  // The hit that completes a refilled load belongs to the miss, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if (r_state == S_IDLE && w_access && !cpu_we) begin
      if (!w_hit)         miss_count <= miss_count + 32'd1;
      else if (!r_refill) hit_count  <= hit_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
// A backing-memory responder acks after ack_wait request cycles; each task checks its own scenario.
module tb_data_cache;
  logic        clk, rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_mode;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_wait = 0;
  logic spur_ack = 1'b0;

  data_cache #(.WIDTH(32), .SETS(64)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: acts 3 time units after each falling edge.
  initial begin
    logic [31:0] mem [0:1023];
    int cnt;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h200 >> 2] = 32'hCAFEF00D;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      #3;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (cnt >= ack_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_we === 1'b1)
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        mem_ack = spur_ack;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic do_load(input logic [2:0] mode, input logic [31:0] addr,
                         output logic [31:0] data, output int cyc);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = mode; cpu_addr = addr;
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 40) begin
      cycle();
      cyc++;
    end
    data = cpu_rdata;
    cycle();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b001; cpu_addr = 32'h100; cpu_wdata = 32'd0;
    cycle();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    cpu_req = 1'b0;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_miss_fill();
    int cyc;
    ack_wait = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b001; cpu_addr = 32'h100;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL miss_stall: got %b want 1", stall); end
    cycle();
    cyc = 1;
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      n_bad++; $display("FAIL fetch_req: got req=%b we=%b be=%h want 1 0 f", mem_req, mem_we, mem_be); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
    while (stall === 1'b1 && cyc < 40) begin
      cycle();
      cyc++;
    end
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL miss_latency: got %0d want 5", cyc); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fill_rdata: got %h want deadbeef", cpu_rdata); end
    n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL fill_miss_count: got %0d want 1", miss_count); end
    cycle();
    n_cmp++; if (stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL repeat_hit: got stall=%b rdata=%h want 0 deadbeef", stall, cpu_rdata); end
    cycle();
    cpu_req = 1'b0;
    #1;
    n_cmp++; if (hit_count !== 32'd1) begin n_bad++; $display("FAIL hit_count_1: got %0d want 1", hit_count); end
  endtask

  task automatic test_extension();
    logic [2:0]  modes [4] = '{3'b011, 3'b101, 3'b010, 3'b100};
    logic [31:0] addrs [4] = '{32'h101, 32'h101, 32'h102, 32'h100};
    logic [31:0] exps  [4] = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = modes[i]; cpu_addr = addrs[i];
      #1;
      n_cmp++; if (stall !== 1'b0 || cpu_rdata !== exps[i]) begin
        n_bad++; $display("FAIL ext_%0d: got stall=%b rdata=%h want 0 %h", i, stall, cpu_rdata, exps[i]); end
      cycle();
    end
    cpu_req = 1'b0;
    #1;
    n_cmp++; if (hit_count !== 32'd5) begin n_bad++; $display("FAIL ext_hit_count: got %0d want 5", hit_count); end
  endtask

  task automatic test_store_hit();
    int cyc;
    ack_wait = 1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = 3'b011; cpu_addr = 32'h103; cpu_wdata = 32'h00000042;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL store_idle: got stall=%b req=%b want 1 0", stall, mem_req); end
    cycle();
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0001 || mem_addr !== 32'h100) begin
      n_bad++; $display("FAIL sb_req: got req=%b we=%b be=%b addr=%h want 1 1 0001 00000100", mem_req, mem_we, mem_be, mem_addr); end
    n_cmp++; if (mem_wdata[7:0] !== 8'h42) begin n_bad++; $display("FAIL sb_wdata: got %h want xxxxxx42", mem_wdata); end
    cyc = 1;
    while (stall === 1'b1 && cyc < 40) begin
      cycle();
      cyc++;
    end
    n_cmp++; if (cyc !== 3 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL sb_done: got cycles=%0d req=%b want 3 0", cyc, mem_req); end
    cycle();
    cpu_we = 1'b0; cpu_mode = 3'b001; cpu_addr = 32'h100;
    #1;
    n_cmp++; if (stall !== 1'b0 || cpu_rdata !== 32'hDEADBE42) begin
      n_bad++; $display("FAIL sb_merge: got stall=%b rdata=%h want 0 deadbe42", stall, cpu_rdata); end
    cycle();
    cpu_req = 1'b0;
  endtask

  task automatic test_conflict();
    logic [31:0] d0, d1, d2;
    int c0, c1, c2;
    pulse_reset();
    ack_wait = 0;
    do_load(3'b001, 32'h100, d0, c0);
    do_load(3'b001, 32'h200, d1, c1);
    do_load(3'b001, 32'h100, d2, c2);
    n_cmp++; if (d0 !== 32'hDEADBE42 || d1 !== 32'hCAFEF00D || d2 !== 32'hDEADBE42) begin
      n_bad++; $display("FAIL conflict_data: got %h %h %h want deadbe42 cafef00d deadbe42", d0, d1, d2); end
    n_cmp++; if (c0 !== 2 || c1 !== 2 || c2 !== 2) begin
      n_bad++; $display("FAIL conflict_latency: got %0d %0d %0d want 2 2 2", c0, c1, c2); end
    n_cmp++; if (miss_count !== 32'd3 || hit_count !== 32'd0) begin
      n_bad++; $display("FAIL conflict_counts: got miss=%0d hit=%0d want 3 0", miss_count, hit_count); end
  endtask

  task automatic test_store_miss();
    int cyc;
    logic [31:0] d;
    ack_wait = 2;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = 3'b001; cpu_addr = 32'h300; cpu_wdata = 32'h12345678;
    #1;
    cycle();
    n_cmp++; if (mem_be !== 4'b1111 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h300 || mem_we !== 1'b1) begin
      n_bad++; $display("FAIL sw_req: got be=%b wdata=%h addr=%h we=%b want 1111 12345678 00000300 1", mem_be, mem_wdata, mem_addr, mem_we); end
    cyc = 1;
    while (stall === 1'b1 && cyc < 40) begin
      cycle();
      cyc++;
    end
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL sw_latency: got %0d want 4", cyc); end
    cycle();
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_no_alloc: got stall=%b want 1", stall); end
    do_load(3'b001, 32'h300, d, cyc);
    n_cmp++; if (d !== 32'h12345678 || miss_count !== 32'd4) begin
      n_bad++; $display("FAIL sw_refetch: got %h miss=%0d want 12345678 4", d, miss_count); end
  endtask

  task automatic test_invalid_and_spurious();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b110; cpu_addr = 32'h100;
    #1;
    n_cmp++; if (stall !== 1'b0 || cpu_rdata !== 32'd0 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL bad_mode: got stall=%b rdata=%h req=%b want 0 0 0", stall, cpu_rdata, mem_req); end
    cycle();
    cpu_req = 1'b0;
    spur_ack = 1'b1;
    cycle();
    cycle();
    spur_ack = 1'b0;
    cycle();
    cpu_req = 1'b1; cpu_mode = 3'b001; cpu_addr = 32'h300;
    #1;
    n_cmp++; if (stall !== 1'b0 || cpu_rdata !== 32'h12345678 || miss_count !== 32'd4) begin
      n_bad++; $display("FAIL spurious_ack: got stall=%b rdata=%h miss=%0d want 0 12345678 4", stall, cpu_rdata, miss_count); end
    cycle();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    ack_wait = 5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b001; cpu_addr = 32'h100;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++; $display("FAIL mid_fetch_reset: got req=%b hit=%0d miss=%0d want 0 0 0", mem_req, hit_count, miss_count); end
    cycle();
    ack_wait = 0;
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL remiss_stall: got %b want 1", stall); end
    cyc = 0;
    while (stall === 1'b1 && cyc < 40) begin
      cycle();
      cyc++;
    end
    n_cmp++; if (cyc !== 2 || cpu_rdata !== 32'hDEADBE42 || miss_count !== 32'd1) begin
      n_bad++; $display("FAIL remiss: got cycles=%0d rdata=%h miss=%0d want 2 deadbe42 1", cyc, cpu_rdata, miss_count); end
    cycle();
    cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_mode = 3'b000; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    @(negedge clk);
    #1;
    test_reset();
    test_miss_fill();
    test_extension();
    test_store_hit();
    test_conflict();
    test_store_miss();
    test_invalid_and_spurious();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits between the CPU memory stage and the word-organised backing data memory.
- Services CPU byte, halfword and word loads and stores using the team's modeBU encoding.
- Stalls the CPU on misses and on every store; talks to backing memory over a req/ack handshake.

Parameters:
- WIDTH, 32: data and address width; fixed at 32.
- SETS, 64: number of one-word lines; power of 2, at least 2.
- IDX = log2(SETS) (derived): index bits. Index = cpu_addr[IDX+1:2]. Tag = cpu_addr[31:IDX+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_mode  in  3  001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_rdata  out  32  load result, extended to 32 bits.
- stall  out  1  CPU must hold its request stable while this is high.
- mem_req  out  1  backing memory request.
- mem_we  out  1  backing memory write.
- mem_addr  out  32  word-aligned address {cpu_addr[31:2],2'b00}.
- mem_be  out  4  byte enables; bit3 = byte at offset 0.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  32  loads that hit.
- miss_count  out  32  loads that missed.

Behaviour:
- Byte order: big-endian within a word. Offset 0 = bits[31:24], offset 3 = bits[7:0].
- Alignment: half accesses use offset {A[1],0}; word accesses ignore A[1:0]. No misalignment traps.
- Valid modes: a mode outside 001–101 is not an access: stall 0, cpu_rdata 0, no memory traffic.
- Storage per line: valid bit, tag, 32-bit data.
- Reset: all valid bits 0; FSM to IDLE; hit_count and miss_count 0; mem_req 0. All outputs return to 0 asynchronously.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE, load hit (cpu_req & !cpu_we & valid & tag match):
  - cpu_rdata is combinational from the line in the same cycle, with lane select and sign/zero extension.
  - stall 0; hit_count +1 at the clock edge.
- IDLE, load miss:
  - stall 1 combinationally; miss_count +1; next state FETCH.
- IDLE, store:
  - stall 1; next state WRITE. A store always stalls.
- FETCH:
  - mem_req 1, mem_we 0, mem_be 4'b1111, stall 1.
  - On mem_ack: line is written with mem_rdata, tag written, valid set; next state IDLE.
  - Back in IDLE the load now hits and completes. Miss latency = ack wait + 2 cycles.
- WRITE:
  - mem_req 1, mem_we 1, stall 1.
  - mem_be: word 1111; half 1100 or 0011 by A[1]; byte one-hot by A[1:0].
  - mem_wdata: cpu_wdata low byte(s) replicated into the selected lane(s).
  - On mem_ack: if the line hits, the enabled bytes are merged into the cached data. A store miss does not allocate. Next state DONE.
- DONE:
  - stall 0 for exactly one cycle so the store retires; next state IDLE.
  - Counters unchanged in DONE.
- Handshake rules:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are stable from assertion until the ack cycle.
  - mem_req is low in IDLE and DONE.
  - mem_ack while mem_req is low is ignored.
  - mem_ack may arrive in the first request cycle (zero wait).
- Counters wrap modulo 2^32.
- In FETCH/WRITE/DONE, cpu_rdata is undefined and must not be consumed.
- Reset mid-FETCH or mid-WRITE: the transaction is abandoned and no line is updated. The next access after reset re-misses.

Test Plan:
- Reset; memory word 0x100 = 0xDEADBEEF; lw 0x100.
  - -> stall 1; mem_req with mem_addr 0x100.
  - Ack after 3 cycles -> next cycle cpu_rdata 0xDEADBEEF, stall 0, miss_count 1.
  - Repeat lw -> same-cycle hit, hit_count 1.
- After fill, check extension: lb 0x101 -> 0xFFFFFFAD; lbu 0x101 -> 0x000000AD; lh 0x102 -> 0xFFFFBEEF; lhu 0x100 -> 0x0000DEAD; all without stall.
- sb 0x103, wdata 0x00000042.
  - -> mem_we 1, mem_be 0001, mem_wdata low byte 0x42; ack; one DONE cycle with stall 0.
  - Then lw 0x100 hits -> 0xDEADBE42.
- SETS=64 conflict: lw 0x100, lw 0x200, lw 0x100.
  - -> three misses; miss_count 3, hit_count 0.
- sw 0x300, data 0x12345678, on a cold line.
  - -> memory write with be 1111; line not allocated.
  - Following lw 0x300 misses and fetches 0x12345678.
- rst pulsed during FETCH (before ack).
  - -> mem_req 0 immediately; counters 0.
  - lw 0x100 afterwards misses again; ack in first request cycle -> result after 2 cycles.
